// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD sequencer: runs the power-up init sequence, then turns
// single-cycle byte write requests into timed RS/DATA setup, EN pulse, hold and execution wait.
module lcd_ctrl #(
  parameter int T_PWRUP_CYC = 750000,
  parameter int T_SETUP_CYC = 2,
  parameter int T_EN_CYC    = 12,
  parameter int T_HOLD_CYC  = 2,
  parameter int T_CMD_CYC   = 2000,
  parameter int T_CLR_CYC   = 82000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic [31:0] lcd_o,
  output logic        busy_o,
  output logic        init_done_o
);

  localparam int M0    = (T_PWRUP_CYC > T_SETUP_CYC) ? T_PWRUP_CYC : T_SETUP_CYC;
  localparam int M1    = (M0 > T_EN_CYC) ? M0 : T_EN_CYC;
  localparam int M2    = (M1 > T_HOLD_CYC) ? M1 : T_HOLD_CYC;
  localparam int M3    = (M2 > T_CMD_CYC) ? M2 : T_CMD_CYC;
  localparam int T_MAX = (M3 > T_CLR_CYC) ? M3 : T_CLR_CYC;
  localparam int CNT_W = $clog2(T_MAX) + 1;

  typedef enum logic [2:0] {PWRUP, SETUP, EN_HI, HOLD, WAIT, IDLE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   last_cnt;
  logic [2:0]         idx_q, idx_d;
  logic               on_q, on_d;
  logic               en_q, en_d;
  logic               rs_q, rs_d;
  logic [7:0]         data_q, data_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cnt_end;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = 8'h38;
      3'd3:             init_rom = 8'h0C;
      3'd4:             init_rom = 8'h01;
      default:          init_rom = 8'h06;
    endcase
  endfunction

  // Clear and Return Home need the long execution wait.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
    is_slow_cmd = !rs && (data == 8'h01 || data == 8'h02 || data == 8'h03);
  endfunction

  always_comb begin
    case (state_q)
      PWRUP:   last_cnt = CNT_W'(T_PWRUP_CYC - 1);
      SETUP:   last_cnt = CNT_W'(T_SETUP_CYC - 1);
      EN_HI:   last_cnt = CNT_W'(T_EN_CYC - 1);
      HOLD:    last_cnt = CNT_W'(T_HOLD_CYC - 1);
      WAIT:    last_cnt = is_slow_cmd(rs_q, data_q) ? CNT_W'(T_CLR_CYC - 1)
                                                    : CNT_W'(T_CMD_CYC - 1);
      default: last_cnt = '0;
    endcase
  end

  assign cnt_end = (cnt_q == last_cnt);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    on_d    = on_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = done_q;
    if (state_q != IDLE && !cnt_end) cnt_d = cnt_q + 1'b1;
    case (state_q)
      PWRUP: begin
        // The first cycle out of reset only switches the display on; the power-up count follows.
        if (!on_q) begin
          on_d  = 1'b1;
          cnt_d = '0;
        end else if (cnt_end) begin
          idx_d   = 3'd0;
          rs_d    = 1'b0;
          data_d  = init_rom(3'd0);
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: if (cnt_end) begin
        en_d    = 1'b1;
        state_d = EN_HI;
        cnt_d   = '0;
      end
      EN_HI: if (cnt_end) begin
        en_d    = 1'b0;
        state_d = HOLD;
        cnt_d   = '0;
      end
      HOLD: if (cnt_end) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (cnt_end) begin
        cnt_d = '0;
        if (!done_q && idx_q < 3'd5) begin
          idx_d   = idx_q + 3'd1;
          data_d  = init_rom(idx_q + 3'd1);
          state_d = SETUP;
        end else begin
          done_d  = 1'b1;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      IDLE: if (req_valid_i && ready_q) begin
        rs_d    = req_rs_i;
        data_d  = req_data_i;
        ready_d = 1'b0;
        busy_d  = 1'b1;
        state_d = SETUP;
        cnt_d   = '0;
      end
      default: state_d = PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PWRUP;
      cnt_q   <= '0;
      idx_q   <= '0;
      on_q    <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      on_q    <= on_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign lcd_o       = {on_q, 20'b0, en_q, rs_q, 1'b0, data_q};
  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign init_done_o = done_q;

endmodule
